uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Configurable UART receiver. Successor to the fixed 8-bit 16x receiver, with:
//  - parametrised data width, oversampling ratio and stop-bit count
//  - runtime parity mode
//  - 3-sample majority voting and false-start rejection
//  - break detection and a one-entry valid/ready output buffer with overrun reporting.
//  Sits between the shared baud-tick generator and the host-side RX FIFO/bus bridge.
// PARAMETERS
//  N_BIT       8   data bits per frame, legal 5..9, LSB received first
//  OVERSAMPLE  16  s_tick pulses per bit, even, legal 8..32
//  STOP_BITS   1   stop bits checked, 1 or 2
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  rst_n         in   1      synchronous active-low reset
//  s_tick        in   1      1-cycle pulse, OVERSAMPLE per bit period
//  rx            in   1      asynchronous serial line, idle high
//  parity_mode   in   2      00 none, 01 even, 10 odd, 11 treated as none
//  dout          out  N_BIT  received data word
//  dout_valid    out  1      dout and flags hold a word
//  dout_ready    in   1      consumer accepts word when dout_valid&&dout_ready
//  parity_err    out  1      word parity mismatch; qualified by dout_valid
//  frame_err     out  1      start or any stop bit voted 0; qualified by dout_valid
//  break_det     out  1      all data, parity and stop bits 0; qualified by dout_valid
//  overrun       out  1      1-cycle pulse: completed frame dropped, buffer full
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - all outputs go to 0; state goes to IDLE; counters and synchroniser clear to 1/idle.
//    - Reset mid-frame abandons the frame; no word is delivered.
//  - rx passes a 2-flop synchroniser (rx_s). All decisions use rx_s, adding 2 clk of latency.
//  - Majority vote: rx_s sampled on s_tick when tick_cnt = H-1, H and H+1, where H=OVERSAMPLE/2.
//    The voted bit is the majority of the 3 samples and is valid at tick H+1.
//  - tick_cnt counts s_tick pulses from 0 to OVERSAMPLE-1 and wraps to 0.
//    Only the s_tick that wraps it ends a bit period.
//  - FSM:
//    - IDLE: rx_s=0 -> START. Clear tick_cnt/bit_cnt. Latch parity_mode (mid-frame changes ignored).
//    - START: at the vote, 1 -> IDLE (false start, no flags). 0 -> continue to the wrap, then DATA.
//    - DATA: vote each bit into shift[bit_cnt], LSB first. At the wrap after bit N_BIT-1:
//      go to PARITY if mode is even/odd, else STOP.
//    - PARITY: vote the bit. Expected value is ^data for even, ~^data for odd.
//      On mismatch set pe_nx. At the wrap go to STOP.
//    - STOP: vote each stop bit; any 0 sets fe_nx. At the vote of the last stop bit, complete the
//      frame (no wait for the bit end). If rx_s=0 go to BRK_WAIT, else IDLE.
//    - BRK_WAIT: hold until rx_s=1, then IDLE. This blocks a false start from a low line.
//  - Break: break_nx=1 when data, parity (if enabled) and all stop votes are 0.
//    A break also sets frame_err.
//  - Frame completion, same cycle:
//    - Buffer empty, or dout_valid && dout_ready: load dout/flags, set dout_valid.
//    - Otherwise: keep the held word, drop the new one, pulse overrun for 1 clk.
//    - Completion and consume in one cycle: the new word replaces the old, no overrun.
//  - Handshake: dout_valid&&dout_ready with no completion clears dout_valid the next cycle.
//    dout/flags stay stable while dout_valid=1 and are don't-care when it is 0.
//  - Delivery: dout_valid rises 1 clk after the last stop-bit vote. That is H+2 ticks into the
//    last stop bit, + 2 clk synchroniser.
//  - s_tick absent: state and counters hold. Only IDLE, BRK_WAIT and reset respond without s_tick.
// TESTING (OVERSAMPLE=16, N_BIT=8, STOP_BITS=1 unless noted)
//  1. 8E1, send 0xA5 (parity 0, stop 1), dout_ready=1 -> dout=0xA5, dout_valid 1 clk, no flags.
//  2. 8O1, send 0x3C with parity bit 0 -> dout=0x3C, parity_err=1.
//     With the same stimulus in 8N1, the parity bit is read as the stop bit: frame_err=1, no parity_err.
//  3. rx low for 5 ticks then high -> no dout_valid, FSM back in IDLE, next frame 0x55 received correctly.
//     A 1-tick low spike inside a data bit at tick H -> bit value unchanged.
//  4. rx held low for 20 bit periods -> one word, dout=0x00, frame_err=1, break_det=1.
//     No further word until rx high and a new start bit.
//  5. dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun pulses once.
//     Assert dout_ready during a 3rd frame's completion cycle -> 0x33 loaded, no overrun.
//  6. rst_n=0 for 1 clk mid-DATA -> all outputs 0 next cycle, no partial word.
//     STOP_BITS=2, N_BIT=7, second stop bit 0 -> frame_err=1.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority voting and false-start rejection.
// Also provides break detection and a one-entry valid/ready output buffer with overrun pulse.
module uart_rx_cfg #(
    parameter int N_BIT      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tick,
    input  logic             rx,
    input  logic [1:0]       parity_mode,
    output logic [N_BIT-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             break_det,
    output logic             overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(N_BIT + 1);

    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(N_BIT - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]        samp_q, samp_d;
    logic [N_BIT-1:0]  shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              zero_q, zero_d;
    logic [N_BIT-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              break_det_q, break_det_d;
    logic              overrun_q, overrun_d;

    logic tick_en, at_vote, at_wrap, vote, par_exp, complete, fe_nx, brk_nx;

    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign par_exp = par_odd_q ? ~^shift_q : ^shift_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        pe_d         = pe_q;
        fe_d         = fe_q;
        zero_d       = zero_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        overrun_d    = 1'b0;
        complete     = 1'b0;
        fe_nx        = fe_q | ~vote;
        brk_nx       = zero_q & ~vote;

        tick_en = s_tick && (state_q == S_START || state_q == S_DATA ||
                             state_q == S_PARITY || state_q == S_STOP);
        at_vote = tick_en && (tick_cnt_q == T_VOTE);
        at_wrap = tick_en && (tick_cnt_q == T_LAST);

        if (tick_en) begin
            tick_cnt_d = at_wrap ? '0 : tick_cnt_q + TW'(1);
            if (tick_cnt_q == T_S0) samp_d[0] = rx_s_q;
            if (tick_cnt_q == T_S1) samp_d[1] = rx_s_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_odd_d  = (parity_mode == 2'b10);
                    pe_d       = 1'b0;
                    fe_d       = 1'b0;
                    zero_d     = 1'b1;
                end
            end
            S_START: begin
                if (at_vote && vote) begin
                    state_d = S_IDLE;
                end else if (at_wrap) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                // Shifting in at the MSB leaves the first-received bit in shift_q[0].
                if (at_vote) begin
                    shift_d = {vote, shift_q[N_BIT-1:1]};
                    zero_d  = zero_q & ~vote;
                end
                if (at_wrap) begin
                    if (bit_cnt_q == B_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_vote) begin
                    zero_d = zero_q & ~vote;
                    if (vote != par_exp) pe_d = 1'b1;
                end
                if (at_wrap) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (at_vote) begin
                    fe_d   = fe_nx;
                    zero_d = brk_nx;
                    if (bit_cnt_q == S_LAST) begin
                        complete = 1'b1;
                        state_d  = rx_s_q ? S_IDLE : S_BRK_WAIT;
                    end
                end
                if (at_wrap) bit_cnt_d = bit_cnt_q + BW'(1);
            end
            S_BRK_WAIT: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A completing word may replace the held one only if that word is consumed this cycle.
        if (complete) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shift_q;
                parity_err_d = pe_q;
                frame_err_d  = fe_nx;
                break_det_d  = brk_nx;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so every output reads 0 after reset.
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            pe_q         <= 1'b0;
            fe_q         <= 1'b0;
            zero_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            pe_q         <= pe_d;
            fe_q         <= fe_d;
            zero_q       <= zero_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule
